// File: rtl/panel_blitter_pkg.sv
// Shared types and constants for the multi-panel sprite blitter.
package blit_pkg;

    localparam int unsigned COLOUR_W = 3;
    localparam logic        BG_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FLUSH,
        DONE
    } state_t;

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/panel_blitter_if.sv
// Plot bus towards vga_adapter plus the shared sprite ROM port.
interface panel_blitter_if
    import blit_pkg::*;
#(
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned NUM_SPRITES = 3
) ();

    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [COLOUR_W-1:0]    colour;
    logic                   plot;
    logic [ADDR_W-1:0]      rom_addr;
    logic [NUM_SPRITES-1:0] rom_q;

    modport master (
        output x, y, colour, plot, rom_addr,
        input  rom_q
    );

    modport slave (
        input  x, y, colour, plot, rom_addr,
        output rom_q
    );

endinterface

// File: rtl/panel_blitter_scanner.sv
// Column/row/panel scan counters with last-pixel detect and sprite-local ROM address.
module panel_scanner
    import blit_pkg::*;
#(
    parameter int unsigned NUM_PANELS = 2,
    parameter int unsigned PANEL_W    = 80,
    parameter int unsigned PANEL_H    = 120,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned CW         = idx_w(PANEL_W),
    parameter int unsigned RW         = idx_w(PANEL_H),
    parameter int unsigned PNW        = idx_w(NUM_PANELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    output logic [CW-1:0]     col,
    output logic [RW-1:0]     row,
    output logic [PNW-1:0]    panel,
    output logic              last,
    output logic [ADDR_W-1:0] rom_addr
);

    logic col_end;
    logic row_end;
    logic panel_end;

    assign col_end   = (col == CW'(PANEL_W - 1));
    assign row_end   = (row == RW'(PANEL_H - 1));
    assign panel_end = (panel == PNW'(NUM_PANELS - 1));
    assign last      = col_end && row_end && panel_end;
    assign rom_addr  = ADDR_W'(row) * ADDR_W'(PANEL_W) + ADDR_W'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            panel <= '0;
        end else if (clear) begin
            col   <= '0;
            row   <= '0;
            panel <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row   <= '0;
                    panel <= panel_end ? '0 : panel + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_blitter.sv
// Multi-panel sprite blitter: FSM, input snapshot, ROM-latency pipeline and colour mux.
module panel_blitter
    import blit_pkg::*;
#(
    parameter int unsigned NUM_PANELS  = 2,
    parameter int unsigned PANEL_W     = 80,
    parameter int unsigned PANEL_H     = 120,
    parameter int unsigned NUM_SPRITES = 3,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned ROM_LAT     = 1
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [NUM_PANELS*SEL_W-1:0]    panel_sel,
    input  logic [NUM_PANELS*COLOUR_W-1:0] fg_colour,
    input  logic [NUM_PANELS*COLOUR_W-1:0] bg_colour,
    output logic                           busy,
    output logic                           done,
    panel_blitter_if.master                bus
);

    localparam int unsigned CW   = idx_w(PANEL_W);
    localparam int unsigned RW   = idx_w(PANEL_H);
    localparam int unsigned PNW  = idx_w(NUM_PANELS);
    localparam int unsigned LAST = ROM_LAT - 1;

    state_t                         state;
    logic [1:0]                     flush_cnt;
    logic [NUM_PANELS*SEL_W-1:0]    sel_snap;
    logic [NUM_PANELS*COLOUR_W-1:0] fg_snap;
    logic [NUM_PANELS*COLOUR_W-1:0] bg_snap;

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [PNW-1:0] panel;
    logic           last;
    logic           accept;

    assign accept = (state == IDLE) && start;

    panel_scanner #(
        .NUM_PANELS (NUM_PANELS),
        .PANEL_W    (PANEL_W),
        .PANEL_H    (PANEL_H),
        .ADDR_W     (ADDR_W),
        .CW         (CW),
        .RW         (RW),
        .PNW        (PNW)
    ) u_scanner (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .clear    (accept),
        .advance  (state == DRAW),
        .col      (col),
        .row      (row),
        .panel    (panel),
        .last     (last),
        .rom_addr (bus.rom_addr)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            sel_snap  <= '0;
            fg_snap   <= '0;
            bg_snap   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_snap <= panel_sel;
                        fg_snap  <= fg_colour;
                        bg_snap  <= bg_colour;
                        busy     <= 1'b1;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
                    if (last) begin
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    // ROM_LAT+1 drain cycles: delay stages plus the output register.
                    if (flush_cnt == 2'(ROM_LAT)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic           v_d   [ROM_LAT];
    logic [PNW-1:0] pan_d [ROM_LAT];
    logic [CW-1:0]  col_d [ROM_LAT];
    logic [RW-1:0]  row_d [ROM_LAT];

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                v_d[i]   <= 1'b0;
                pan_d[i] <= '0;
                col_d[i] <= '0;
                row_d[i] <= '0;
            end
        end else begin
            v_d[0]   <= (state == DRAW);
            pan_d[0] <= panel;
            col_d[0] <= col;
            row_d[0] <= row;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                v_d[i]   <= v_d[i-1];
                pan_d[i] <= pan_d[i-1];
                col_d[i] <= col_d[i-1];
                row_d[i] <= row_d[i-1];
            end
        end
    end

    logic [SEL_W-1:0] sel_d;
    logic             pix_bit;

    // Selects outside the ROM set leave pix_bit at background.
    always_comb begin
        sel_d   = sel_snap[pan_d[LAST]*SEL_W +: SEL_W];
        pix_bit = BG_BIT;
        for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
            if (sel_d == SEL_W'(s)) pix_bit = bus.rom_q[s];
        end
    end

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= v_d[LAST];
            if (v_d[LAST]) begin
                x_q      <= X_W'(pan_d[LAST]) * X_W'(PANEL_W) + X_W'(col_d[LAST]);
                y_q      <= Y_W'(row_d[LAST]);
                colour_q <= (pix_bit == BG_BIT) ? bg_snap[pan_d[LAST]*COLOUR_W +: COLOUR_W]
                                                : fg_snap[pan_d[LAST]*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;

endmodule

// File: tb/tb_panel_blitter.sv
// Self-checking bench: ROM_LAT=1 and ROM_LAT=3 blitters driven in lockstep against a frame model.
module tb_panel_blitter;

    localparam int NP   = 2;
    localparam int PW   = 4;
    localparam int PH   = 3;
    localparam int NPIX = NP * PW * PH;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] panel_sel;
    logic [5:0] fg_colour;
    logic [5:0] bg_colour;
    logic       busy1, done1, busy3, done3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    panel_blitter_if #(.X_W(8), .Y_W(7), .ADDR_W(15), .NUM_SPRITES(3)) bus1 ();
    panel_blitter_if #(.X_W(8), .Y_W(7), .ADDR_W(15), .NUM_SPRITES(3)) bus3 ();

    panel_blitter #(.NUM_PANELS(NP), .PANEL_W(PW), .PANEL_H(PH), .ROM_LAT(1)) dut1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .panel_sel(panel_sel),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .busy(busy1), .done(done1), .bus(bus1));

    panel_blitter #(.NUM_PANELS(NP), .PANEL_W(PW), .PANEL_H(PH), .ROM_LAT(3)) dut3 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .panel_sel(panel_sel),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .busy(busy3), .done(done3), .bus(bus3));

    // Sprite ROM content: sprite s holds the parity of (address + s).
    function automatic logic sprite_bit(input int s, input int a);
        return ($countones(a + s) % 2) == 1;
    endfunction

    function automatic logic [2:0] rom_bits(input logic [14:0] a);
        logic [2:0] b;
        for (int s = 0; s < 3; s++) b[s] = sprite_bit(s, int'(a));
        return b;
    endfunction

    logic [2:0] q1, q3a, q3b, q3c;
    always @(posedge CLOCK_50) begin
        q1  <= rom_bits(bus1.rom_addr);
        q3a <= rom_bits(bus3.rom_addr);
        q3b <= q3a;
        q3c <= q3b;
    end
    assign bus1.rom_q = q1;
    assign bus3.rom_q = q3c;

    function automatic logic [2:0] model_colour(input logic [3:0] sel, input logic [5:0] fg,
                                                input logic [5:0] bg, input int p, input int r,
                                                input int c);
        int   s;
        logic b;
        s = int'((sel >> (2 * p)) & 4'd3);
        b = (s >= 3) ? 1'b1 : sprite_bit(s, r * PW + c);
        return b ? bg[3*p +: 3] : fg[3*p +: 3];
    endfunction

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         lab;
    } plot_t;

    plot_t pq1[$], pq3[$];
    int    dq1[$], dq3[$];
    int    bc1, bc3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int lab);
        if (bus1.plot) pq1.push_back('{bus1.x, bus1.y, bus1.colour, lab});
        if (bus3.plot) pq3.push_back('{bus3.x, bus3.y, bus3.colour, lab});
        if (busy1) bc1++;
        if (busy3) bc3++;
        if (done1) dq1.push_back(lab);
        if (done3) dq3.push_back(lab);
    endtask

    task automatic check_dut(input int which, input int k, input logic [3:0] sel,
                             input logic [5:0] fg, input logic [5:0] bg,
                             input int first_off, input int done_off);
        plot_t q[$];
        int    dq[$];
        int    bc;
        int    i;
        string t;
        if (which == 1) begin q = pq1; dq = dq1; bc = bc1; t = "L1"; end
        else            begin q = pq3; dq = dq3; bc = bc3; t = "L3"; end
        chk({t, " plot_count"}, q.size(), NPIX);
        if (q.size() > 0) begin
            chk({t, " first_plot_cycle"}, q[0].lab - k, first_off);
            chk({t, " contiguous"}, q[q.size()-1].lab - q[0].lab, q.size() - 1);
        end
        i = 0;
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++) begin
                    if (i < q.size())
                        chk($sformatf("%s pixel%0d xyc", t, i), {q[i].x, q[i].y, q[i].c},
                            {8'(p * PW + c), 7'(r), model_colour(sel, fg, bg, p, r, c)});
                    i++;
                end
        chk({t, " done_count"}, dq.size(), 1);
        if (dq.size() > 0) chk({t, " done_cycle"}, dq[0] - k, done_off);
        chk({t, " busy_cycles"}, bc, done_off - 1);
    endtask

    task automatic run_draw(input logic [3:0] sel, input logic [5:0] fg, input logic [5:0] bg,
                            input int first_off, input int done_off, input bit interfere);
        int k;
        pq1.delete(); pq3.delete(); dq1.delete(); dq3.delete();
        bc1 = 0; bc3 = 0;
        panel_sel = sel; fg_colour = fg; bg_colour = bg;
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        k = cyc;
        sample(cyc + 1);
        for (int n = 1; n < 45; n++) begin
            @(negedge CLOCK_50);
            sample(cyc + 1);
            if (interfere) begin
                // n=6 lands mid-DRAW; n=26 lands in DONE (ROM_LAT=1) / FLUSH (ROM_LAT=3).
                if (n == 6 || n == 26) begin
                    panel_sel = ~sel; fg_colour = ~fg; bg_colour = ~bg; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_dut(1, k, sel, fg, bg, first_off, done_off);
        check_dut(3, k, sel, fg, bg, first_off + 2, done_off + 2);
    endtask

    typedef struct {
        logic [3:0] sel;
        logic [5:0] fg;
        logic [5:0] bg;
        int         first_off;
        int         done_off;
    } vec_t;

    vec_t tbl[$];
    int   stray;
    int   seen;
    bit   hit;

    initial begin
        reset_n = 1'b0; start = 1'b0;
        panel_sel = '0; fg_colour = '0; bg_colour = '0;

        repeat (3) @(negedge CLOCK_50);
        chk("reset L1 outputs", {bus1.x, bus1.y, bus1.colour, bus1.plot, busy1, done1}, 0);
        chk("reset L1 rom_addr", bus1.rom_addr, 0);
        chk("reset L3 outputs", {bus3.x, bus3.y, bus3.colour, bus3.plot, busy3, done3}, 0);
        reset_n = 1'b1;

        stray = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLOCK_50);
            if (bus1.plot || busy1 || done1 || bus3.plot || busy3 || done3) stray++;
        end
        chk("idle no activity", stray, 0);
        chk("idle xyc", {bus1.x, bus1.y, bus1.colour, bus3.x, bus3.y, bus3.colour}, 0);

        tbl.push_back('{4'b0100, 6'b010_010, 6'b000_111, 3, 27});
        tbl.push_back('{4'b1110, 6'b101_011, 6'b110_001, 3, 27});
        tbl.push_back('{4'b1000, 6'b001_100, 6'b111_010, 3, 27});
        tbl.push_back('{4'b0011, 6'b100_101, 6'b011_110, 3, 27});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{4'($urandom), 6'($urandom), 6'($urandom), 3, 27});
        foreach (tbl[i])
            run_draw(tbl[i].sel, tbl[i].fg, tbl[i].bg, tbl[i].first_off, tbl[i].done_off, 1'b0);

        run_draw(4'b0110, 6'b011_101, 6'b100_010, 3, 27, 1'b1);

        // Reset asserted when the ROM_LAT=1 blitter shows its tenth plot.
        panel_sel = 4'b0100; fg_colour = 6'b010_010; bg_colour = 6'b000_111;
        @(negedge CLOCK_50); start = 1'b1;
        @(negedge CLOCK_50); start = 1'b0;
        seen = 0; hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            if (n > 0) @(negedge CLOCK_50);
            if (bus1.plot) seen++;
            if (seen == 10) begin
                hit = 1'b1;
                reset_n = 1'b0;
                #1;
                chk("midreset L1 outputs", {bus1.x, bus1.y, bus1.colour, bus1.plot, busy1, done1}, 0);
                chk("midreset L1 rom_addr", bus1.rom_addr, 0);
                chk("midreset L3 outputs", {bus3.x, bus3.y, bus3.colour, bus3.plot, busy3, done3}, 0);
            end
        end
        chk("midreset reached plot 10", hit, 1);
        stray = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLOCK_50);
            if (done1 || done3 || bus1.plot || bus3.plot) stray++;
        end
        chk("midreset quiet", stray, 0);
        reset_n = 1'b1;
        run_draw(4'b0100, 6'b010_010, 6'b000_111, 3, 27, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
